sync_dual_rail_tx: RTL and testbench



---
 rtl/sync_dual_rail_tx_pkg.sv | 35 +++
 rtl/sync_dual_rail_tx_ack_sync.sv | 23 ++
 rtl/sync_dual_rail_tx.sv | 109 ++++++++++
 tb/tb_sync_dual_rail_tx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_dual_rail_tx_pkg.sv
// Shared types for the dual-rail async datapath: rail pair, transmitter states and
// the binary to dual-rail encoder.
package pa_AsyncCordic;

    typedef struct packed {
        logic data_1;
        logic data_0;
    } dual_rail_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        SPACER = 2'd2
    } tx_state_e;

    localparam int unsigned MAX_W = 64;
    typedef dual_rail_t [MAX_W-1:0] dr_word_t;

    function automatic dual_rail_t encode_bit(input logic b);
        dual_rail_t r;
        r.data_1 = b;
        r.data_0 = ~b;
        return r;
    endfunction

    // Word-wide encoder; narrower words are zero-extended by the caller.
    function automatic dr_word_t encode(input logic [MAX_W-1:0] word);
        dr_word_t r;
        for (int i = 0; i < MAX_W; i++) begin
            r[i] = encode_bit(word[i]);
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_dual_rail_tx_ack_sync.sv
// Flop-chain synchronizer for an asynchronous acknowledge; clears to 0 on reset.
module AsyncAckSynchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/sync_dual_rail_tx.sv
// Clocked front end of the dual-rail pipeline: accepts a word, drives its codeword and
// runs a 4-phase return-to-zero handshake against the synchronized receiver ack.
module sync_dual_rail_tx
    import pa_AsyncCordic::*;
#(
    parameter int SIZE        = 7,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SIZE:0]        in_data,
    output dual_rail_t [SIZE:0]  dr_o,
    input  logic                 ack_i,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int PRIME_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]   TO_VAL    = CNT_W'(TIMEOUT);
    localparam logic [PRIME_W-1:0] PRIME_END = PRIME_W'(SYNC_STAGES);

    tx_state_e             state;
    logic                  ack_s;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_inc;
    logic [PRIME_W-1:0]    prime_cnt;
    logic                  primed;
    dual_rail_t [SIZE:0]   enc;

    AsyncAckSynchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack_i),
        .q   (ack_s)
    );

    always_comb begin
        enc = '0;
        for (int i = 0; i <= SIZE; i++) begin
            enc[i] = encode_bit(in_data[i]);
        end
    end

    // ack_s only reflects ack_i once the synchronizer has refilled after reset, so the
    // SPACER exit is held off until then; a receiver still holding ack is not missed.
    assign primed  = (prime_cnt == PRIME_END);
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SPACER;
            dr_o        <= '0;
            in_ready    <= 1'b0;
            busy        <= 1'b1;
            cnt         <= '0;
            timeout_err <= 1'b0;
            prime_cnt   <= '0;
        end else begin
            if (!primed) begin
                prime_cnt <= prime_cnt + PRIME_W'(1);
            end
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        dr_o     <= enc;
                        state    <= EVAL;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        cnt      <= '0;
                    end
                end
                EVAL: begin
                    if (ack_s) begin
                        dr_o  <= '0;
                        state <= SPACER;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                        if (TIMEOUT != 0 && cnt_inc == TO_VAL) timeout_err <= 1'b1;
                    end
                end
                SPACER: begin
                    if (primed && !ack_s) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt_inc;
                        if (TIMEOUT != 0 && cnt_inc == TO_VAL) timeout_err <= 1'b1;
                    end
                end
                default: begin
                    state    <= SPACER;
                    dr_o     <= '0;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    cnt      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_dual_rail_tx.sv
// Self-checking bench for sync_dual_rail_tx: directed handshake scenarios plus a
// randomized receiver, scored against a word queue and the dual-rail encoding rules.
module tb_sync_dual_rail_tx;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int TO = 15;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic [2*W-1:0] dr_o;
    logic           ack_i;
    logic           busy;
    logic           timeout_err;

    logic [1:0]     mode;      // 0 manual ack, 1 instant loopback, 2 random receiver
    logic           ack_man;
    logic           rx_ack;
    int             errors = 0;
    int             checks = 0;
    int             cyc = 0;
    int             cw_count = 0;
    logic [W-1:0]   exp_q[$];
    logic [2*W-1:0] prev_dr = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ack_i = (mode == 2'd1) ? (dr_o != '0) : (mode == 2'd2) ? rx_ack : ack_man;

    sync_dual_rail_tx #(.SIZE(W-1), .SYNC_STAGES(S), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .dr_o        (dr_o),
        .ack_i       (ack_i),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference encoding: rail pair i is {data_1, data_0} = {b, ~b}.
    function automatic logic [2*W-1:0] enc(input logic [W-1:0] w);
        logic [2*W-1:0] r;
        for (int i = 0; i < W; i++) begin
            r[2*i+1] = w[i];
            r[2*i]   = ~w[i];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rails1(input logic [2*W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[2*i+1];
        return r;
    endfunction

    function automatic logic [W-1:0] rails0(input logic [2*W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[2*i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers a word and waits (bounded) for the transmitter to take it.
    task automatic send(input logic [W-1:0] w, output int acc_cyc);
        acc_cyc  = -1;
        in_valid = 1'b1;
        in_data  = w;
        for (int k = 0; k < 60; k++) begin
            if (in_ready) begin
                exp_q.push_back(w);
                acc_cyc = cyc;
                tick();
                in_valid = 1'b0;
                in_data  = W'($urandom);
                return;
            end
            tick();
        end
        in_valid = 1'b0;
        check("send_timeout", 32'd0, 32'd1);
    endtask

    // Rail monitor: no 11 pair, no codeword-to-codeword step, codewords match accepted words.
    always @(negedge clk) begin
        logic [W-1:0] bad;
        bad = rails1(dr_o) & rails0(dr_o);
        if (bad != '0) check("rail_11", 32'(bad), 32'd0);
        if (prev_dr != '0 && dr_o != '0 && dr_o != prev_dr)
            check("cw_to_cw", 32'(dr_o), 32'(prev_dr));
        if (prev_dr == '0 && dr_o != '0) begin
            cw_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_cw", 32'(dr_o), 32'd0);
            end else begin
                check("codeword", 32'(dr_o), 32'(enc(exp_q.pop_front())));
            end
        end
        prev_dr = dr_o;
    end

    // Random receiver: raises ack some cycles after a codeword, drops it after the spacer.
    initial begin
        int phase;
        int dly;
        phase  = 0;
        dly    = 0;
        rx_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (mode == 2'd2) begin
                case (phase)
                    0: if (dr_o != '0) begin dly = $urandom_range(0, 3); phase = 1; end
                    1: if (dly == 0) begin rx_ack = 1'b1; phase = 2; end else dly--;
                    2: if (dr_o == '0) begin dly = $urandom_range(0, 3); phase = 3; end
                    default: if (dly == 0) begin rx_ack = 1'b0; phase = 0; end else dly--;
                endcase
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc[3];
        int a;
        int base;
        logic [W-1:0] words[3];
        words = '{8'h00, 8'hFF, 8'h3C};

        mode = 2'd0; ack_man = 1'b0; in_valid = 1'b1; in_data = 8'h77; rst = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_dr", 32'(dr_o), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);

        // Release reset: ready appears S+1 cycles later, rails stay spacer.
        rst = 1'b0; in_valid = 1'b0;
        for (int k = 1; k <= S + 1; k++) begin
            tick();
            check("rel_in_ready", 32'(in_ready), (k == S + 1) ? 32'd1 : 32'd0);
            check("rel_dr", 32'(dr_o), 32'd0);
        end
        check("idle_busy", 32'(busy), 32'd0);

        // Accept A5, hold ack low with in_data churning: rails frozen, timeout on 15th cycle.
        send(8'hA5, a);
        check("a5_data1", 32'(rails1(dr_o)), 32'hA5);
        check("a5_data0", 32'(rails0(dr_o)), 32'h5A);
        for (int t = 1; t <= 20; t++) begin
            in_data = W'($urandom);
            tick();
            check("eval_hold_dr", 32'(dr_o), 32'(enc(8'hA5)));
            check("eval_in_ready", 32'(in_ready), 32'd0);
            check("eval_timeout", 32'(timeout_err), (t >= TO) ? 32'd1 : 32'd0);
        end
        ack_man = 1'b1;
        for (int k = 1; k <= S + 1; k++) begin
            tick();
            check("ack_to_spacer", 32'(dr_o), (k == S + 1) ? 32'd0 : 32'(enc(8'hA5)));
        end
        ack_man = 1'b0;
        for (int k = 1; k <= S + 1; k++) begin
            tick();
            check("ret_in_ready", 32'(in_ready), (k == S + 1) ? 32'd1 : 32'd0);
        end
        check("timeout_sticky", 32'(timeout_err), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("timeout_clr", 32'(timeout_err), 32'd0);
        for (int k = 0; k < S + 1; k++) tick();
        check("post_rst_ready", 32'(in_ready), 32'd1);

        // Loopback: three back-to-back words.
        mode = 2'd1;
        base = cw_count;
        for (int i = 0; i < 3; i++) send(words[i], acc[i]);
        for (int k = 0; k < 40 && !in_ready; k++) tick();
        check("lb_idle", 32'(in_ready), 32'd1);
        check("lb_cw_count", 32'(cw_count - base), 32'd3);
        check("lb_period_eq", 32'(acc[2] - acc[1]), 32'(acc[1] - acc[0]));
        check("lb_period_max", 32'((acc[1] - acc[0]) <= 2 * (S + 1) + 2), 32'd1);
        check("lb_period_min", 32'((acc[1] - acc[0]) >= 2 * S + 2), 32'd1);

        // Receiver holding ack across reset: stay in SPACER until it drops.
        mode = 2'd0; ack_man = 1'b1; rst = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("ackhold_ready", 32'(in_ready), 32'd0);
            check("ackhold_busy", 32'(busy), 32'd1);
        end
        ack_man = 1'b0;
        for (int k = 1; k <= S + 1; k++) begin
            tick();
            check("ackdrop_ready", 32'(in_ready), (k == S + 1) ? 32'd1 : 32'd0);
        end
        check("ackhold_timeout", 32'(timeout_err), 32'd0);

        // Random words against the random receiver.
        mode = 2'd2;
        base = cw_count;
        for (int n = 0; n < 30; n++) begin
            for (int g = $urandom_range(0, 3); g > 0; g--) tick();
            send(W'($urandom), a);
        end
        for (int k = 0; k < 100 && !(in_ready && exp_q.size() == 0); k++) tick();
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_cw_count", 32'(cw_count - base), 32'd30);
        check("rand_timeout", 32'(timeout_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
